// File: rtl/mod5_seq_monitor_pkg.sv
// ---------------------------------------------------------------------------
// mod5_mon_pkg
// Shared definitions for the mod-5 sequence monitor:
//   - monitor state encoding
//   - fault cause codes reported on err_code
//   - last legal count value and the successor function of the mod-5 counter
// ---------------------------------------------------------------------------
package mod5_mon_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } mon_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_SKIP    = 2'b10;
    localparam logic [1:0] ERR_STUCK   = 2'b11;

    localparam logic [2:0] MOD5_LAST = 3'd4;

    // Expected successor of a legal count; the last value wraps to 0.
    function automatic logic [2:0] mod5_next(input logic [2:0] prev);
        return (prev >= MOD5_LAST) ? 3'd0 : prev + 3'd1;
    endfunction

endpackage

// File: rtl/mod5_seq_monitor_if.sv
// ---------------------------------------------------------------------------
// mod5_seq_monitor_if
// Groups the sampled counter input and the decoded/status outputs of the
// mod-5 sequence monitor.
//   en          sample enable (master -> monitor)
//   q_in[2:0]   counter value (master -> monitor)
//   err_clr     fault clear, only when MOD5_SEQ_MONITOR_ERR_CLR_EN is defined
//   phase[4:0]  one-hot phase decode (monitor -> master)
//   wrap_pulse  one-cycle pulse per accepted 4->0 wrap
//   wrap_count  accepted wrap counter, WRAP_W bits
//   err         sticky fault flag
//   err_code    first fault cause
// Macro: MOD5_SEQ_MONITOR_ERR_CLR_EN adds err_clr.
// ---------------------------------------------------------------------------
interface mod5_seq_monitor_if #(
    parameter int WRAP_W = 8
);
    logic              en;
    logic [2:0]        q_in;
`ifdef MOD5_SEQ_MONITOR_ERR_CLR_EN
    logic              err_clr;
`endif
    logic [4:0]        phase;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic              err;
    logic [1:0]        err_code;

`ifdef MOD5_SEQ_MONITOR_ERR_CLR_EN
    modport master (
        output en, q_in, err_clr,
        input  phase, wrap_pulse, wrap_count, err, err_code
    );
    modport slave (
        input  en, q_in, err_clr,
        output phase, wrap_pulse, wrap_count, err, err_code
    );
`else
    modport master (
        output en, q_in,
        input  phase, wrap_pulse, wrap_count, err, err_code
    );
    modport slave (
        input  en, q_in,
        output phase, wrap_pulse, wrap_count, err, err_code
    );
`endif

endinterface

// File: rtl/mod5_seq_monitor_step_check.sv
// ---------------------------------------------------------------------------
// mod5_step_check
// Combinational classifier of one counter sample against the previously
// accepted value while the monitor is tracking.
//   prev_i[2:0]   last accepted count (always 0..4)
//   q_in_i[2:0]   new sample
//   accept_o      sample is a legal continuation
//   is_wrap_o     accepted sample is the 4->0 wrap
//   fault_o       sample is a fault
//   code_o[1:0]   fault cause when fault_o is set
// ---------------------------------------------------------------------------
module mod5_step_check
    import mod5_mon_pkg::*;
(
    input  logic [2:0] prev_i,
    input  logic [2:0] q_in_i,
    output logic       accept_o,
    output logic       is_wrap_o,
    output logic       fault_o,
    output logic [1:0] code_o
);

    // Branch order is the classification priority: illegal code first, then
    // any zero (wrap, hold or upstream resync), then the normal successor.
    always_comb begin
        accept_o  = 1'b0;
        is_wrap_o = 1'b0;
        fault_o   = 1'b0;
        code_o    = ERR_NONE;
        if (q_in_i > MOD5_LAST) begin
            fault_o = 1'b1;
            code_o  = ERR_ILLEGAL;
        end else if (q_in_i == 3'd0) begin
            accept_o  = 1'b1;
            is_wrap_o = (prev_i == MOD5_LAST);
        end else if (prev_i != MOD5_LAST && q_in_i == mod5_next(prev_i)) begin
            accept_o = 1'b1;
        end else if (q_in_i == prev_i) begin
            // q_in_i is nonzero here, so prev_i is nonzero as well
            fault_o = 1'b1;
            code_o  = ERR_STUCK;
        end else begin
            fault_o = 1'b1;
            code_o  = ERR_SKIP;
        end
    end

endmodule

// File: rtl/mod5_seq_monitor.sv
// ---------------------------------------------------------------------------
// mod5_seq_monitor
// Samples a mod-5 counter (0,1,2,3,4,0,...), registers a one-hot phase
// decode, counts accepted wraps and latches the first sequencing fault.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   bus        mod5_seq_monitor_if.slave (en, q_in, [err_clr], phase,
//              wrap_pulse, wrap_count, err, err_code)
// Parameters:
//   WRAP_W     width of wrap_count
//   WRAP_SAT   0: wrap_count rolls over, 1: saturates at all-ones
// Macro: MOD5_SEQ_MONITOR_ERR_CLR_EN enables err_clr to leave the fault
//   state without a reset.
// ---------------------------------------------------------------------------
module mod5_seq_monitor #(
    parameter int WRAP_W   = 8,
    parameter int WRAP_SAT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    mod5_seq_monitor_if.slave       bus
);
    import mod5_mon_pkg::*;

    localparam logic [WRAP_W-1:0] CNT_ONE = WRAP_W'(1);

    mon_state_e        state_q, state_d;
    logic [2:0]        prev_q, prev_d;
    logic [4:0]        phase_q, phase_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              chk_accept;
    logic              chk_wrap;
    logic              chk_fault;
    logic [1:0]        chk_code;

    mod5_step_check u_step_check (
        .prev_i    (prev_q),
        .q_in_i    (bus.q_in),
        .accept_o  (chk_accept),
        .is_wrap_o (chk_wrap),
        .fault_o   (chk_fault),
        .code_o    (chk_code)
    );

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        phase_d      = phase_q;
        wrap_pulse_d = 1'b0;
        wrap_cnt_d   = wrap_cnt_q;
        err_d        = err_q;
        err_code_d   = err_code_q;

        if (bus.en) begin
            case (state_q)
                ST_INIT: begin
                    // Only a fresh 0 lets tracking start
                    if (bus.q_in == 3'd0) begin
                        state_d = ST_TRACK;
                        prev_d  = 3'd0;
                        phase_d = 5'b00001;
                    end else if (bus.q_in > MOD5_LAST) begin
                        state_d    = ST_FAULT;
                        phase_d    = 5'b00000;
                        err_d      = 1'b1;
                        err_code_d = ERR_ILLEGAL;
                    end else begin
                        phase_d = 5'b00000;
                    end
                end
                ST_TRACK: begin
                    if (chk_fault) begin
                        state_d    = ST_FAULT;
                        phase_d    = 5'b00000;
                        err_d      = 1'b1;
                        err_code_d = chk_code;
                    end else if (chk_accept) begin
                        prev_d  = bus.q_in;
                        phase_d = 5'b00001 << bus.q_in;
                        if (chk_wrap) begin
                            wrap_pulse_d = 1'b1;
                            if (WRAP_SAT != 0 && (&wrap_cnt_q))
                                wrap_cnt_d = wrap_cnt_q;
                            else
                                wrap_cnt_d = wrap_cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_FAULT: begin
                    // First cause stays latched; later samples are ignored
                    phase_d = 5'b00000;
                    err_d   = 1'b1;
`ifdef MOD5_SEQ_MONITOR_ERR_CLR_EN
                    if (bus.err_clr) begin
                        state_d    = ST_INIT;
                        prev_d     = 3'd0;
                        err_d      = 1'b0;
                        err_code_d = ERR_NONE;
                    end
`endif
                end
                default: begin
                    state_d = ST_INIT;
                    phase_d = 5'b00000;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_INIT;
            prev_q       <= 3'd0;
            phase_q      <= 5'b00000;
            wrap_pulse_q <= 1'b0;
            wrap_cnt_q   <= '0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            phase_q      <= phase_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_cnt_q   <= wrap_cnt_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign bus.phase      = phase_q;
    assign bus.wrap_pulse = wrap_pulse_q;
    assign bus.wrap_count = wrap_cnt_q;
    assign bus.err        = err_q;
    assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_mod5_seq_monitor.sv
// ---------------------------------------------------------------------------
// tb_mod5_seq_monitor
// Three monitors driven by the same stimulus: WRAP_W=8 rollover (main),
// WRAP_W=2 rollover and WRAP_W=2 saturating. Vectors carry the expected
// outputs one edge after the sample; wrap counts for the 2-bit instances are
// derived from the expected wrap total.
// Macro: MOD5_SEQ_MONITOR_ERR_CLR_EN adds the err_clr sequence.
// ---------------------------------------------------------------------------
module tb_mod5_seq_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] q_in;
`ifdef MOD5_SEQ_MONITOR_ERR_CLR_EN
    logic       err_clr;
`endif

    always #5 clk = ~clk;

    mod5_seq_monitor_if #(.WRAP_W(8)) bus8  ();
    mod5_seq_monitor_if #(.WRAP_W(2)) bus2r ();
    mod5_seq_monitor_if #(.WRAP_W(2)) bus2s ();

    assign bus8.en    = en;
    assign bus8.q_in  = q_in;
    assign bus2r.en   = en;
    assign bus2r.q_in = q_in;
    assign bus2s.en   = en;
    assign bus2s.q_in = q_in;
`ifdef MOD5_SEQ_MONITOR_ERR_CLR_EN
    assign bus8.err_clr  = err_clr;
    assign bus2r.err_clr = err_clr;
    assign bus2s.err_clr = err_clr;
`endif

    mod5_seq_monitor #(.WRAP_W(8), .WRAP_SAT(0)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
    mod5_seq_monitor #(.WRAP_W(2), .WRAP_SAT(0)) dut2r (.clk(clk), .rst(rst), .bus(bus2r));
    mod5_seq_monitor #(.WRAP_W(2), .WRAP_SAT(1)) dut2s (.clk(clk), .rst(rst), .bus(bus2s));

    typedef struct {
        bit         rst_b;   // pulse reset before applying this vector
        bit         en;
        logic [2:0] q;
        bit         clr;
        logic [4:0] ph;
        bit         wp;
        int         wc;      // expected total of accepted wraps
        bit         err;
        logic [1:0] code;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t V(bit rb, bit e, int q, bit c, int ph, bit wp, int wc, bit er, int cd);
        vec_t v;
        v.rst_b = rb;
        v.en    = e;
        v.q     = 3'(q);
        v.clr   = c;
        v.ph    = 5'(ph);
        v.wp    = wp;
        v.wc    = wc;
        v.err   = er;
        v.code  = 2'(cd);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk("rst_phase", 32'(bus8.phase), 0);
        chk("rst_wp",    32'(bus8.wrap_pulse), 0);
        chk("rst_wc8",   32'(bus8.wrap_count), 0);
        chk("rst_wc2r",  32'(bus2r.wrap_count), 0);
        chk("rst_wc2s",  32'(bus2s.wrap_count), 0);
        chk("rst_err",   32'(bus8.err), 0);
        chk("rst_code",  32'(bus8.err_code), 0);
        #2;
        rst = 1'b1;
    endtask

    task automatic check_out(input int idx);
        vec_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: vector %0d has no expectation", idx);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("v%0d_phase", idx), 32'(bus8.phase), 32'(e.ph));
            chk($sformatf("v%0d_wp", idx),    32'(bus8.wrap_pulse), 32'(e.wp));
            chk($sformatf("v%0d_wc8", idx),   32'(bus8.wrap_count), 32'(e.wc % 256));
            chk($sformatf("v%0d_wc2r", idx),  32'(bus2r.wrap_count), 32'(e.wc % 4));
            chk($sformatf("v%0d_wc2s", idx),  32'(bus2s.wrap_count), 32'((e.wc > 3) ? 3 : e.wc));
            chk($sformatf("v%0d_err", idx),   32'(bus8.err), 32'(e.err));
            chk($sformatf("v%0d_code", idx),  32'(bus8.err_code), 32'(e.code));
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        if (v.rst_b) do_reset();
        en   = v.en;
        q_in = v.q;
`ifdef MOD5_SEQ_MONITOR_ERR_CLR_EN
        err_clr = v.clr;
`endif
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_out(idx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- stimulus table ----------------
        // Five full counter cycles, then the next step
        tbl.push_back(V(1, 1, 0, 0, 1, 0, 0, 0, 0));
        for (int c = 1; c <= 5; c++) begin
            tbl.push_back(V(0, 1, 1, 0, 2,  0, c - 1, 0, 0));
            tbl.push_back(V(0, 1, 2, 0, 4,  0, c - 1, 0, 0));
            tbl.push_back(V(0, 1, 3, 0, 8,  0, c - 1, 0, 0));
            tbl.push_back(V(0, 1, 4, 0, 16, 0, c - 1, 0, 0));
            tbl.push_back(V(0, 1, 0, 0, 1,  1, c,     0, 0));
        end
        // en low right after a wrap: pulse drops, everything else freezes
        tbl.push_back(V(0, 0, 5, 0, 1, 0, 5, 0, 0));
        tbl.push_back(V(0, 0, 3, 0, 1, 0, 5, 0, 0));
        tbl.push_back(V(0, 0, 7, 0, 1, 0, 5, 0, 0));
        tbl.push_back(V(0, 1, 1, 0, 2, 0, 5, 0, 0));
        tbl.push_back(V(0, 1, 2, 0, 4, 0, 5, 0, 0));
        // Skip 2->4, then later faults must not overwrite the cause
        tbl.push_back(V(0, 1, 4, 0, 0, 0, 5, 1, 2));
        tbl.push_back(V(0, 1, 7, 0, 0, 0, 5, 1, 2));
        tbl.push_back(V(0, 1, 0, 0, 0, 0, 5, 1, 2));
        // Resync 0,1,2,0 and hold 0,0,0, then stuck 1,1 (async reset in fault first)
        tbl.push_back(V(1, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 1, 0, 2, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 2, 0, 4, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 1, 0, 2, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 1, 0, 0, 0, 0, 1, 3));
        // INIT: nonzero legal value waits, illegal value faults
        tbl.push_back(V(1, 1, 3, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 6, 0, 0, 0, 0, 1, 1));
        tbl.push_back(V(0, 1, 0, 0, 0, 0, 0, 1, 1));
        // INIT wait then skip 0->4
        tbl.push_back(V(1, 1, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 4, 0, 0, 0, 0, 1, 2));
        // Stuck at the last value
        tbl.push_back(V(1, 1, 0, 0, 1,  0, 0, 0, 0));
        tbl.push_back(V(0, 1, 1, 0, 2,  0, 0, 0, 0));
        tbl.push_back(V(0, 1, 2, 0, 4,  0, 0, 0, 0));
        tbl.push_back(V(0, 1, 3, 0, 8,  0, 0, 0, 0));
        tbl.push_back(V(0, 1, 4, 0, 16, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 4, 0, 0,  0, 0, 1, 3));
`ifdef MOD5_SEQ_MONITOR_ERR_CLR_EN
        // err_clr: ignored in TRACK, clears fault to INIT, keeps wrap count
        tbl.push_back(V(1, 1, 0, 0, 1,  0, 0, 0, 0));
        tbl.push_back(V(0, 1, 1, 0, 2,  0, 0, 0, 0));
        tbl.push_back(V(0, 1, 2, 0, 4,  0, 0, 0, 0));
        tbl.push_back(V(0, 1, 3, 0, 8,  0, 0, 0, 0));
        tbl.push_back(V(0, 1, 4, 0, 16, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 0, 0, 1,  1, 1, 0, 0));
        tbl.push_back(V(0, 1, 1, 1, 2,  0, 1, 0, 0));
        tbl.push_back(V(0, 1, 1, 0, 0,  0, 1, 1, 3));
        tbl.push_back(V(0, 1, 0, 1, 0,  0, 1, 0, 0));
        tbl.push_back(V(0, 1, 0, 0, 1,  0, 1, 0, 0));
        tbl.push_back(V(0, 1, 1, 0, 2,  0, 1, 0, 0));
`endif

        // ---------------- run ----------------
        en   = 1'b0;
        q_in = 3'd0;
`ifdef MOD5_SEQ_MONITOR_ERR_CLR_EN
        err_clr = 1'b0;
`endif
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Async reset while in fault clears outputs with no clock edge
        do_reset();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod5_seq_monitor.md
Name: mod5_seq_monitor

Overview:
- Downstream consumer of the 3-bit mod-5 counter output (sequence 0,1,2,3,4,0).
- Samples the count and decodes it to a registered one-hot phase vector for downstream control logic.
- Counts completed wrap-arounds and flags illegal codes, skips and stuck values with a sticky error.

Parameters:
- WRAP_W, 8, width of wrap_count.
- WRAP_SAT, 0, 0 = wrap_count rolls over modulo 2^WRAP_W; 1 = wrap_count saturates at all-ones.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample enable; 0 = hold all state and outputs.
- q_in  input  3  count value from the mod-5 counter.
- phase  output  5  registered one-hot decode: bit k set when the accepted count equals k.
- wrap_pulse  output  1  one-cycle pulse on each accepted 4->0 transition.
- wrap_count  output  WRAP_W  number of accepted wraps.
- err  output  1  sticky fault flag.
- err_code  output  2  first fault cause: 00 none, 01 ILLEGAL (5..7), 10 SKIP, 11 STUCK.
- err_clr  input  1  present only with the optional feature.

Behaviour:
- Reset (rst=0, async) drives: state=INIT, phase=0, wrap_pulse=0, wrap_count=0, err=0, err_code=00, prev=0.
- Outputs are registered. The effect of a sample at edge N is visible after edge N. The pipeline latency is 1 cycle.
- en=0: no state change, no checking, and wrap_pulse=0 on the next cycle. Other outputs hold.
- wrap_pulse is high only on the cycle following an accepted wrap sample.
- INIT state:
  - q_in=0 -> TRACK, phase=00001, prev=0.
  - q_in in 1..4 -> stay INIT, phase=0.
  - q_in in 5..7 -> FAULT, code ILLEGAL.
- TRACK state, classify q_in against prev in this priority order:
  1. q_in in 5..7 -> FAULT, code ILLEGAL.
  2. q_in=0:
     - prev=4 is an accepted wrap: wrap_pulse=1, wrap_count increments (with WRAP_SAT rule).
     - prev=0 is an accepted hold (upstream held in its synchronous reset).
     - prev in 1..3 is an accepted resync (upstream reset mid-count); no wrap is counted.
     - In all three cases phase=00001.
  3. q_in = prev+1 (prev in 0..3) -> accepted; phase updates.
  4. q_in = prev with prev != 0 -> FAULT, code STUCK.
  5. Any other value -> FAULT, code SKIP.
- FAULT state:
  - phase=0, err=1.
  - err_code holds the first cause and is never overwritten.
  - wrap_count holds.
  - Exit only via reset, or via err_clr when the feature is enabled.
- wrap_count boundary:
  - WRAP_SAT=0: all-ones + 1 = 0.
  - WRAP_SAT=1: stays at all-ones.
- Reset asserted mid-operation returns immediately to the reset values. After reset release, the block requires a fresh 0 to enter TRACK.

Optional Feature:
- Macro: MOD5_SEQ_MONITOR_ERR_CLR_EN.
- Defined: err_clr port exists. err_clr=1 sampled in FAULT clears err and err_code to 00 and moves to INIT. The sample in that cycle is ignored. err_clr is ignored in INIT and TRACK. err_clr does not clear wrap_count.
- Undefined: no err_clr port; FAULT is left only by reset.

Decomposition:
- Package mod5_mon_pkg:
  - State enum {INIT, TRACK, FAULT}.
  - err_code constants ERR_NONE, ERR_ILLEGAL, ERR_SKIP, ERR_STUCK.
  - MOD5_LAST = 3'd4.
  - Function mod5_next(prev) returning the expected successor.
- One natural combinational sub-module, mod5_step_check (inputs prev, q_in; outputs accept, is_wrap, fault, code), which isolates the classification priority.

Test Plan:
- Reset then en=1, q_in cycling 0,1,2,3,4,0,1 -> phase 00001,00010,00100,01000,10000,00001,00010 one cycle later; wrap_pulse high exactly once; wrap_count=1; err=0.
- WRAP_W=2, WRAP_SAT=0, 5 full cycles -> wrap_count 1,2,3,0,1. Same run with WRAP_SAT=1 -> wrap_count stops at 3.
- After reaching TRACK, sequence 0,1,3 -> err=1, err_code=10, phase=0. Then apply 7 -> err_code remains 10.
- Sequences 0,1,2,0 (resync) and 0,0,0 (hold) -> no error, no wrap_pulse. Sequence 0,1,1 -> err_code=11. q_in=6 in INIT -> err_code=01.
- en=0 for 3 cycles mid-sequence with q_in changing (including illegal 5) -> outputs frozen and no fault. Resume with correct successor -> no error.
- Assert rst low between edges during FAULT -> outputs clear immediately without a clock edge. With the macro defined, pulse err_clr in FAULT -> INIT and err_code=00; the next 0 re-enters TRACK.
